// File: rtl/mmio_hex_display_pkg.sv
// Shared constants and types for the memory-mapped four-digit hex display.
// Covers bus command codes, register offsets, FSM state codes and the blank segment pattern.
package mmio_hex_display_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 26;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned ST_W   = 2;

  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [ADDR_W-1:0] OFS_DATA   = 9'd0;
  localparam logic [ADDR_W-1:0] OFS_CTRL   = 9'd1;
  localparam logic [ADDR_W-1:0] OFS_STATUS = 9'd2;

  localparam logic [ST_W-1:0] ST_OFF  = 2'd0;
  localparam logic [ST_W-1:0] ST_SHOW = 2'd1;
  localparam logic [ST_W-1:0] ST_HIDE = 2'd2;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // CTRL register layout: bit1 BLINK, bit0 EN
  typedef struct packed {
    logic blink;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/mmio_hex_display_hex7seg.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex7seg
  import mmio_hex_display_pkg::*;
(
  input  logic [3:0]       nib_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mmio_hex_display.sv
// Memory-mapped DATA/CTRL/STATUS registers driving four hex digits with optional blinking.
// HEX5 shows the FSM state code; read_data floats unless one of our addresses is read.
module mmio_hex_display
  import mmio_hex_display_pkg::*;
#(
  parameter int unsigned       BLINK_DIV = 25000000,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 9'h120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output wire  [DATA_W-1:0] read_data,
  output logic [SEG_W-1:0]  HEX0,
  output logic [SEG_W-1:0]  HEX1,
  output logic [SEG_W-1:0]  HEX2,
  output logic [SEG_W-1:0]  HEX3,
  output logic [SEG_W-1:0]  HEX5
);

  localparam logic [ADDR_W-1:0] ADDR_DATA   = ADDR_W'(BASE_ADDR + OFS_DATA);
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(BASE_ADDR + OFS_CTRL);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(BASE_ADDR + OFS_STATUS);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(BLINK_DIV - 1);

  logic [DATA_W-1:0] data_q, data_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ST_W-1:0]   state_q, state_d;

  logic hit_data, hit_ctrl, hit_status, own_addr;
  logic wr_data, wr_ctrl, rd_hit;
  logic cnt_last, toggle, phase, show;
  logic [DATA_W-1:0] rd_val;
  logic [SEG_W-1:0]  dig_seg [4];

  assign hit_data   = (mem_addr == ADDR_DATA);
  assign hit_ctrl   = (mem_addr == ADDR_CTRL);
  assign hit_status = (mem_addr == ADDR_STATUS);
  assign own_addr   = hit_data | hit_ctrl | hit_status;

  assign wr_data = (mem_cmd == MWRITE) && hit_data;
  assign wr_ctrl = (mem_cmd == MWRITE) && hit_ctrl;
  assign rd_hit  = (mem_cmd == MREAD) && own_addr && !reset;

  assign cnt_last = (cnt_q == CNT_LAST);
  // A CTRL write on the terminal count wins: counter clears and the phase holds
  assign toggle   = ctrl_q.blink && cnt_last && !wr_ctrl;
  assign phase    = (state_q == ST_HIDE);
  assign show     = (state_q == ST_SHOW);

  // Register file and blink counter next-state
  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    cnt_d  = '0;
    if (wr_data) data_d = write_data;
    if (wr_ctrl) ctrl_d = ctrl_t'(write_data[1:0]);
    if (!wr_ctrl && ctrl_q.blink && (state_q == ST_SHOW || state_q == ST_HIDE)) begin
      cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Display FSM next-state, driven by CTRL as registered at the previous edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:  if (ctrl_q.en) state_d = ST_SHOW;
      ST_SHOW: begin
        if (!ctrl_q.en)  state_d = ST_OFF;
        else if (toggle) state_d = ST_HIDE;
      end
      ST_HIDE: begin
        if (!ctrl_q.en)         state_d = ST_OFF;
        else if (!ctrl_q.blink) state_d = ST_SHOW;
        else if (toggle)        state_d = ST_SHOW;
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      state_q <= ST_OFF;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    rd_val = '0;
    if (hit_data)        rd_val = data_q;
    else if (hit_ctrl)   rd_val = {14'b0, ctrl_q};
    else if (hit_status) rd_val = {13'b0, phase, state_q};
  end

  assign read_data = rd_hit ? rd_val : {DATA_W{1'bz}};

  for (genvar i = 0; i < 4; i++) begin : g_dig
    hex7seg u_seg (
      .nib_i (data_q[4*i +: 4]),
      .seg_o (dig_seg[i])
    );
  end

  hex7seg u_state_seg (
    .nib_i ({2'b00, state_q}),
    .seg_o (HEX5)
  );

  assign HEX0 = show ? dig_seg[0] : SEG_BLANK;
  assign HEX1 = show ? dig_seg[1] : SEG_BLANK;
  assign HEX2 = show ? dig_seg[2] : SEG_BLANK;
  assign HEX3 = show ? dig_seg[3] : SEG_BLANK;

endmodule
